// File: rtl/lc3_control_fsm_pkg.sv
// lc3_ctrl_pkg: shared encodings for the LC-3 control unit.
//  - state_t uses the classic LC-3 microsequencer state numbers.
//    FAULT is 63.
//  - The package also holds opcode constants, the datapath mux and ALU
//    encodings, and the bit positions inside the ld/gate vectors.
package lc3_ctrl_pkg;

    typedef enum logic [5:0] {
        S_ADD       = 6'd1,
        S_LD        = 6'd2,
        S_ST        = 6'd3,
        S_AND       = 6'd5,
        S_LDR       = 6'd6,
        S_STR       = 6'd7,
        S_NOT       = 6'd9,
        S_JMP       = 6'd12,
        S_LEA       = 6'd14,
        S_TRAP      = 6'd15,
        S_ST_WAIT   = 6'd16,
        S_FETCH0    = 6'd18,
        S_BR_TAKE   = 6'd22,
        S_ST_MDR    = 6'd23,
        S_LD_WAIT   = 6'd25,
        S_LD_WB     = 6'd27,
        S_TRAP_MAR  = 6'd28,
        S_TRAP_WAIT = 6'd29,
        S_TRAP_PC   = 6'd30,
        S_DECODE    = 6'd32,
        S_FETCH1    = 6'd33,
        S_FETCH2    = 6'd35,
        S_FAULT     = 6'd63
    } state_t;

    localparam logic [3:0] OP_BR   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_LDR  = 4'd6;
    localparam logic [3:0] OP_STR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_LEA  = 4'd14;
    localparam logic [3:0] OP_TRAP = 4'd15;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOT  = 2'b11;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    // ld = {mar,mdr,ir,pc,reg,cc}
    localparam int LD_MAR = 5;
    localparam int LD_MDR = 4;
    localparam int LD_IR  = 3;
    localparam int LD_PC  = 2;
    localparam int LD_REG = 1;
    localparam int LD_CC  = 0;

    // gate = {pc,mdr,alu,marmux}
    localparam int GATE_PC     = 3;
    localparam int GATE_MDR    = 2;
    localparam int GATE_ALU    = 1;
    localparam int GATE_MARMUX = 0;

    function automatic logic br_taken(input logic [2:0] nzp, input logic n, input logic z,
                                      input logic p);
        return (nzp[2] & n) | (nzp[1] & z) | (nzp[0] & p);
    endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if: bundles the signals between the control unit and
// the datapath/memory.
//  Inputs to control:    ir, n, z, p, mem_ready
//  Outputs from control: ld, gate, sel_pcmux, sel_addr1, sel_addr2,
//                        sel_mdr, alu_op, sr1, sr2, dr, mem_en, mem_we,
//                        fault, state
//  Modports:
//   - master: the control unit
//   - slave:  the datapath side
interface lc3_control_fsm_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic [DATA_W-1:0] ir;
    logic              n, z, p;
    logic              mem_ready;
    logic [5:0]        ld;
    logic [3:0]        gate;
    logic [1:0]        sel_pcmux;
    logic              sel_addr1;
    logic [1:0]        sel_addr2;
    logic              sel_mdr;
    logic [1:0]        alu_op;
    logic [REG_AW-1:0] sr1, sr2, dr;
    logic              mem_en, mem_we;
    logic              fault;
    logic [5:0]        state;

    modport master (
        input  ir, n, z, p, mem_ready,
        output ld, gate, sel_pcmux, sel_addr1, sel_addr2, sel_mdr, alu_op,
               sr1, sr2, dr, mem_en, mem_we, fault, state
    );

    modport slave (
        output ir, n, z, p, mem_ready,
        input  ld, gate, sel_pcmux, sel_addr1, sel_addr2, sel_mdr, alu_op,
               sr1, sr2, dr, mem_en, mem_we, fault, state
    );
endinterface

// File: rtl/lc3_mem_wait.sv
// lc3_mem_wait: memory wait qualifier and timeout counter.
//  This block is shared by all memory wait states.
//  Ports:
//   - clk, reset_n: clock and asynchronous active-low reset
//   - active:       the FSM is currently in a wait state
//   - mem_ready:    memory completes the access this cycle
//   - done:         the access completes this cycle
//   - timeout:      the last permitted cycle passed without mem_ready
//  Counter behaviour:
//   - The counter is held at zero outside wait states, so it starts
//     from zero on entry to each wait state.
//   - mem_ready is still accepted when the count equals MEM_TIMEOUT.
//   - MEM_TIMEOUT = 0 turns the timeout off.
module lc3_mem_wait #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic mem_ready,
    output logic done,
    output logic timeout
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!active || mem_ready)
            cnt <= '0;
        else if (cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    assign done    = active & mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (cnt == LIMIT);
endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore microsequencer for the LC-3 datapath.
//  Ports:
//   - clk, reset_n: clock and asynchronous active-low reset
//   - bus:          lc3_control_fsm_if.master
//                   (ir/flags/mem_ready in, datapath controls out)
//  Decode of outputs:
//   - Outputs decode the current state plus the register fields of ir.
//   - The one exception is ld.mdr in the memory-read wait states.
//     It follows mem_ready so that MDR captures exactly in the
//     completing cycle.
//  Fault behaviour:
//   - An illegal opcode or a memory timeout parks the FSM in FAULT.
//   - It stays there until reset.
//  Configuration macro LC3_TRAP_EN:
//   - Defined: opcode 15 runs the TRAP sequence.
//   - Undefined: opcode 15 faults.
module lc3_control_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    lc3_control_fsm_if.master  bus
);
    state_t            state;
    logic [3:0]        opcode;
    logic              wait_act, wait_done, wait_tmo;

    logic [5:0]        ld;
    logic [3:0]        gate;
    logic [1:0]        sel_pcmux, sel_addr2, alu_op;
    logic              sel_addr1, sel_mdr, mem_en, mem_we, fault;
    logic [REG_AW-1:0] sr1, sr2, dr;

    assign opcode   = bus.ir[DATA_W-1 -: 4];
    assign wait_act = (state == S_FETCH1) || (state == S_LD_WAIT) ||
                      (state == S_ST_WAIT) || (state == S_TRAP_WAIT);

    lc3_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk       (clk),
        .reset_n   (reset_n),
        .active    (wait_act),
        .mem_ready (bus.mem_ready),
        .done      (wait_done),
        .timeout   (wait_tmo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH0;
        end else begin
            case (state)
                S_FETCH0: state <= S_FETCH1;
                S_FETCH1: if (wait_done) state <= S_FETCH2; else if (wait_tmo) state <= S_FAULT;
                S_FETCH2: state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        // Branches resolve here so a not-taken BR costs no extra cycle.
                        OP_BR:   state <= br_taken(bus.ir[11:9], bus.n, bus.z, bus.p) ?
                                          S_BR_TAKE : S_FETCH0;
                        OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR,
                        OP_ST, OP_STR, OP_JMP, OP_LEA:
                                 state <= state_t'({2'b00, opcode});
`ifdef LC3_TRAP_EN
                        OP_TRAP: state <= S_TRAP;
`endif
                        default: state <= S_FAULT;
                    endcase
                end
                S_ADD, S_AND, S_NOT, S_LEA, S_JMP,
                S_BR_TAKE, S_LD_WB, S_TRAP_PC:  state <= S_FETCH0;
                S_LD, S_LDR:  state <= S_LD_WAIT;
                S_LD_WAIT:    if (wait_done) state <= S_LD_WB;   else if (wait_tmo) state <= S_FAULT;
                S_ST, S_STR:  state <= S_ST_MDR;
                S_ST_MDR:     state <= S_ST_WAIT;
                S_ST_WAIT:    if (wait_done) state <= S_FETCH0;  else if (wait_tmo) state <= S_FAULT;
                S_TRAP:       state <= S_TRAP_MAR;
                S_TRAP_MAR:   state <= S_TRAP_WAIT;
                S_TRAP_WAIT:  if (wait_done) state <= S_TRAP_PC; else if (wait_tmo) state <= S_FAULT;
                S_FAULT:      state <= S_FAULT;
                default:      state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        ld        = '0;
        gate      = '0;
        sel_pcmux = PCMUX_INC;
        sel_addr1 = 1'b0;
        sel_addr2 = ADDR2_ZERO;
        sel_mdr   = 1'b0;
        alu_op    = ALU_PASS;
        sr1       = REG_AW'(bus.ir[8:6]);
        sr2       = REG_AW'(bus.ir[2:0]);
        dr        = REG_AW'(bus.ir[11:9]);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        fault     = 1'b0;
        case (state)
            S_FETCH0: begin
                gate[GATE_PC] = 1'b1;
                ld[LD_MAR]    = 1'b1;
                ld[LD_PC]     = 1'b1;
            end
            S_FETCH1, S_LD_WAIT, S_TRAP_WAIT: begin
                mem_en     = 1'b1;
                sel_mdr    = 1'b1;
                ld[LD_MDR] = wait_done;
            end
            S_FETCH2: begin
                gate[GATE_MDR] = 1'b1;
                ld[LD_IR]      = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                gate[GATE_ALU] = 1'b1;
                ld[LD_REG]     = 1'b1;
                ld[LD_CC]      = 1'b1;
                alu_op = (state == S_ADD) ? ALU_ADD : (state == S_AND) ? ALU_AND : ALU_NOT;
            end
            S_LEA: begin
                sel_addr2         = ADDR2_OFF9;
                gate[GATE_MARMUX] = 1'b1;
                ld[LD_REG]        = 1'b1;
            end
            S_LD, S_ST: begin
                sel_addr2         = ADDR2_OFF9;
                gate[GATE_MARMUX] = 1'b1;
                ld[LD_MAR]        = 1'b1;
            end
            S_LDR, S_STR: begin
                sel_addr1         = 1'b1;
                sel_addr2         = ADDR2_OFF6;
                gate[GATE_MARMUX] = 1'b1;
                ld[LD_MAR]        = 1'b1;
            end
            S_LD_WB: begin
                gate[GATE_MDR] = 1'b1;
                ld[LD_REG]     = 1'b1;
                ld[LD_CC]      = 1'b1;
            end
            S_ST_MDR: begin
                // Store source sits in the DR field; ALU passes it through to the bus.
                sr1            = REG_AW'(bus.ir[11:9]);
                gate[GATE_ALU] = 1'b1;
                ld[LD_MDR]     = 1'b1;
            end
            S_ST_WAIT: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            S_BR_TAKE: begin
                sel_pcmux = PCMUX_ADDR;
                sel_addr2 = ADDR2_OFF9;
                ld[LD_PC] = 1'b1;
            end
            S_JMP: begin
                sel_pcmux      = PCMUX_BUS;
                gate[GATE_ALU] = 1'b1;
                ld[LD_PC]      = 1'b1;
            end
            S_TRAP: begin
                dr            = REG_AW'(7);
                gate[GATE_PC] = 1'b1;
                ld[LD_REG]    = 1'b1;
            end
            S_TRAP_MAR: begin
                // MARMUX presents zext(trapvect8) in this state.
                gate[GATE_MARMUX] = 1'b1;
                ld[LD_MAR]        = 1'b1;
            end
            S_TRAP_PC: begin
                sel_pcmux      = PCMUX_BUS;
                gate[GATE_MDR] = 1'b1;
                ld[LD_PC]      = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
        // While in reset every control is quiet.
        // This drops mem_en immediately when reset_n falls mid-access.
        if (!reset_n) begin
            ld = '0; gate = '0; sel_pcmux = '0; sel_addr1 = 1'b0; sel_addr2 = '0;
            sel_mdr = 1'b0; alu_op = '0; sr1 = '0; sr2 = '0; dr = '0;
            mem_en = 1'b0; mem_we = 1'b0; fault = 1'b0;
        end
    end

    assign bus.ld        = ld;
    assign bus.gate      = gate;
    assign bus.sel_pcmux = sel_pcmux;
    assign bus.sel_addr1 = sel_addr1;
    assign bus.sel_addr2 = sel_addr2;
    assign bus.sel_mdr   = sel_mdr;
    assign bus.alu_op    = alu_op;
    assign bus.sr1       = sr1;
    assign bus.sr2       = sr2;
    assign bus.dr        = dr;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.fault     = fault;
    assign bus.state     = state;
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed bench for lc3_control_fsm.
//  DUT instances:
//   - u0 uses MEM_TIMEOUT=15.
//   - u1 uses MEM_TIMEOUT=2 and exercises the timeout path.
//  How it works:
//   - Each stimulus cycle pushes its hand-written expected outputs.
//   - A negedge monitor pops and compares one entry per cycle.
module tb_lc3_control_fsm;
    logic clk;
    logic rst0_n, rst1_n;

    lc3_control_fsm_if #(.DATA_W(16), .REG_AW(3)) b0 ();
    lc3_control_fsm_if #(.DATA_W(16), .REG_AW(3)) b1 ();

    lc3_control_fsm #(.DATA_W(16), .REG_AW(3), .MEM_TIMEOUT(15)) u0 (
        .clk(clk), .reset_n(rst0_n), .bus(b0.master));
    lc3_control_fsm #(.DATA_W(16), .REG_AW(3), .MEM_TIMEOUT(2)) u1 (
        .clk(clk), .reset_n(rst1_n), .bus(b1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         u;
        string      nm;
        logic [5:0] st;
        logic [5:0] ld;
        logic [3:0] gate;
        logic       men, mwe, flt;
        logic [2:0] xm;      // extra checks: bit0 pcmux, bit1 dr, bit2 sr1
        logic [1:0] pcm;
        logic [2:0] dr, sr1;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   miss = 0;

    task automatic cyc(input int u, input string nm, input logic [5:0] st, input logic [5:0] ld,
                       input logic [3:0] g, input logic men = 1'b0, input logic mwe = 1'b0,
                       input logic flt = 1'b0, input logic [2:0] xm = 3'b000,
                       input logic [1:0] pcm = 2'b00, input logic [2:0] dr = 3'd0,
                       input logic [2:0] sr1 = 3'd0);
        exp_t e;
        e.u = u; e.nm = nm; e.st = st; e.ld = ld; e.gate = g; e.men = men; e.mwe = mwe;
        e.flt = flt; e.xm = xm; e.pcm = pcm; e.dr = dr; e.sr1 = sr1;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic set_rdy(input int u, input logic v);
        if (u == 0) b0.mem_ready = v; else b1.mem_ready = v;
    endtask

    // Best-case fetch and decode: 18, 33 (ready at once), 35, 32.
    task automatic fetch(input int u);
        set_rdy(u, 1'b1);
        cyc(u, "fetch18", 6'd18, 6'b100100, 4'b1000);
        cyc(u, "fetch33", 6'd33, 6'b010000, 4'b0000, 1'b1);
        cyc(u, "fetch35", 6'd35, 6'b001000, 4'b0100);
        cyc(u, "decode",  6'd32, 6'b000000, 4'b0000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [5:0] a_st, a_ld;
        logic [3:0] a_g;
        logic       a_en, a_we, a_f, bad;
        logic [1:0] a_pcm;
        logic [2:0] a_dr, a_sr1;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.u == 0) begin
                a_st = b0.state; a_ld = b0.ld; a_g = b0.gate; a_en = b0.mem_en; a_we = b0.mem_we;
                a_f = b0.fault; a_pcm = b0.sel_pcmux; a_dr = b0.dr; a_sr1 = b0.sr1;
            end else begin
                a_st = b1.state; a_ld = b1.ld; a_g = b1.gate; a_en = b1.mem_en; a_we = b1.mem_we;
                a_f = b1.fault; a_pcm = b1.sel_pcmux; a_dr = b1.dr; a_sr1 = b1.sr1;
            end
            bad = (a_st !== e.st) || (a_ld !== e.ld) || (a_g !== e.gate) || (a_en !== e.men) ||
                  (a_we !== e.mwe) || (a_f !== e.flt) ||
                  (e.xm[0] && (a_pcm !== e.pcm)) || (e.xm[1] && (a_dr !== e.dr)) ||
                  (e.xm[2] && (a_sr1 !== e.sr1));
            vecs++;
            if (bad) begin
                miss++;
                $display("FAIL u%0d %s: got st=%0d ld=%b gate=%b en=%b we=%b flt=%b pcm=%b dr=%0d sr1=%0d; want st=%0d ld=%b gate=%b en=%b we=%b flt=%b pcm=%b dr=%0d sr1=%0d (xm=%b)",
                         e.u, e.nm, a_st, a_ld, a_g, a_en, a_we, a_f, a_pcm, a_dr, a_sr1,
                         e.st, e.ld, e.gate, e.men, e.mwe, e.flt, e.pcm, e.dr, e.sr1, e.xm);
            end
        end
    end

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        b0.ir = '0; b0.n = 1'b0; b0.z = 1'b0; b0.p = 1'b0; b0.mem_ready = 1'b0;
        b1.ir = '0; b1.n = 1'b0; b1.z = 1'b0; b1.p = 1'b0; b1.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, "reset0", 6'd18, 6'b0, 4'b0);
        cyc(1, "reset1", 6'd18, 6'b0, 4'b0);
        rst0_n = 1'b1;

        // ADD R1,R2,R3
        b0.ir = 16'h1283;
        fetch(0);
        cyc(0, "add", 6'd1, 6'b000011, 4'b0010, 0, 0, 0, 3'b110, 2'b00, 3'd1, 3'd2);

        // Fetch with mem_ready three cycles late
        set_rdy(0, 1'b0);
        cyc(0, "slow18", 6'd18, 6'b100100, 4'b1000);
        for (int i = 0; i < 3; i++) cyc(0, "slow33w", 6'd33, 6'b000000, 4'b0000, 1'b1);
        set_rdy(0, 1'b1);
        cyc(0, "slow33r", 6'd33, 6'b010000, 4'b0000, 1'b1);
        cyc(0, "slow35",  6'd35, 6'b001000, 4'b0100);
        cyc(0, "slow32",  6'd32, 6'b000000, 4'b0000);
        cyc(0, "slowadd", 6'd1,  6'b000011, 4'b0010);

        // LD R1 with a one-cycle memory read
        b0.ir = 16'h2205;
        fetch(0);
        cyc(0, "ld_mar",  6'd2,  6'b100000, 4'b0001);
        cyc(0, "ld_wait", 6'd25, 6'b010000, 4'b0000, 1'b1);
        cyc(0, "ld_wb",   6'd27, 6'b000011, 4'b0100, 0, 0, 0, 3'b010, 2'b00, 3'd1);

        // BRz taken, then BRz not taken with only n set
        b0.ir = 16'h0405; b0.z = 1'b1; b0.n = 1'b0; b0.p = 1'b0;
        fetch(0);
        cyc(0, "br_take", 6'd22, 6'b000100, 4'b0000, 0, 0, 0, 3'b001, 2'b10);
        b0.z = 1'b0; b0.n = 1'b1;
        fetch(0);

        // ST R1, one wait cycle before mem_ready
        b0.ir = 16'h3200;
        fetch(0);
        cyc(0, "st_mar", 6'd3,  6'b100000, 4'b0001);
        cyc(0, "st_mdr", 6'd23, 6'b010000, 4'b0010, 0, 0, 0, 3'b100, 2'b00, 3'd0, 3'd1);
        set_rdy(0, 1'b0);
        cyc(0, "st_w0",  6'd16, 6'b000000, 4'b0000, 1'b1, 1'b1);
        set_rdy(0, 1'b1);
        cyc(0, "st_w1",  6'd16, 6'b000000, 4'b0000, 1'b1, 1'b1);

        // NOT, JMP, LEA
        b0.ir = 16'h927F;
        fetch(0);
        cyc(0, "not", 6'd9,  6'b000011, 4'b0010);
        b0.ir = 16'hC1C0;
        fetch(0);
        cyc(0, "jmp", 6'd12, 6'b000100, 4'b0010, 0, 0, 0, 3'b001, 2'b01);
        b0.ir = 16'hE205;
        fetch(0);
        cyc(0, "lea", 6'd14, 6'b000010, 4'b0001, 0, 0, 0, 3'b010, 2'b00, 3'd1);

        // Reset asserted mid-fetch: 18 at once, mem_en dropped
        set_rdy(0, 1'b0);
        cyc(0, "ar18", 6'd18, 6'b100100, 4'b1000);
        cyc(0, "ar33", 6'd33, 6'b000000, 4'b0000, 1'b1);
        rst0_n = 1'b0;
        cyc(0, "arst33", 6'd18, 6'b000000, 4'b0000);
        rst0_n = 1'b1;

        // TRAP x25
        b0.ir = 16'hF025;
        fetch(0);
`ifdef LC3_TRAP_EN
        cyc(0, "trap15", 6'd15, 6'b000010, 4'b1000, 0, 0, 0, 3'b010, 2'b00, 3'd7);
        cyc(0, "trap28", 6'd28, 6'b100000, 4'b0001);
        cyc(0, "trap29", 6'd29, 6'b010000, 4'b0000, 1'b1);
        cyc(0, "trap30", 6'd30, 6'b000100, 4'b0100, 0, 0, 0, 3'b001, 2'b01);
        fetch(0);
        cyc(0, "trap15b", 6'd15, 6'b000010, 4'b1000);
        cyc(0, "trap28b", 6'd28, 6'b100000, 4'b0001);
        set_rdy(0, 1'b0);
        cyc(0, "trap29w", 6'd29, 6'b000000, 4'b0000, 1'b1);
        rst0_n = 1'b0;
        cyc(0, "arst29", 6'd18, 6'b000000, 4'b0000);
        rst0_n = 1'b1;
`else
        cyc(0, "trap_flt",  6'd63, 6'b0, 4'b0, 0, 0, 1'b1);
        cyc(0, "trap_flt2", 6'd63, 6'b0, 4'b0, 0, 0, 1'b1);
        rst0_n = 1'b0;
        cyc(0, "flt_rst", 6'd18, 6'b0, 4'b0);
        rst0_n = 1'b1;
`endif
        cyc(0, "post18", 6'd18, 6'b100100, 4'b1000);

        // u1 (MEM_TIMEOUT=2): ready at count 2 still accepted, then LD times out
        rst1_n = 1'b1;
        b1.ir = 16'h2205;
        cyc(1, "t18", 6'd18, 6'b100100, 4'b1000);
        set_rdy(1, 1'b0);
        cyc(1, "t33w0", 6'd33, 6'b000000, 4'b0000, 1'b1);
        cyc(1, "t33w1", 6'd33, 6'b000000, 4'b0000, 1'b1);
        set_rdy(1, 1'b1);
        cyc(1, "t33lim", 6'd33, 6'b010000, 4'b0000, 1'b1);
        cyc(1, "t35", 6'd35, 6'b001000, 4'b0100);
        cyc(1, "t32", 6'd32, 6'b000000, 4'b0000);
        cyc(1, "t2",  6'd2,  6'b100000, 4'b0001);
        set_rdy(1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1, "t25w", 6'd25, 6'b000000, 4'b0000, 1'b1);
        cyc(1, "tflt0", 6'd63, 6'b0, 4'b0, 0, 0, 1'b1);
        set_rdy(1, 1'b1);
        cyc(1, "tflt1", 6'd63, 6'b0, 4'b0, 0, 0, 1'b1);
        rst1_n = 1'b0;
        cyc(1, "trst", 6'd18, 6'b0, 4'b0);
        rst1_n = 1'b1;
        cyc(1, "trel", 6'd18, 6'b100100, 4'b1000);

        @(posedge clk); #1;
        if (q.size() != 0) begin
            miss++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
